// File: rtl/ibex_mprf_port_arbiter.sv
// Shares the two MPRF RAM ports between core operand reads, core writeback,
// NoC inbound writes and the descriptor send sequencer.
module ibex_mprf_port_arbiter #(
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LenWidth  = 5,
    parameter int unsigned DstWidth  = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 core_rd_i,
    input  logic [AddrWidth-1:0] core_raddr_a_i,
    input  logic [AddrWidth-1:0] core_raddr_b_i,
    output logic [DataWidth-1:0] core_rdata_a_o,
    output logic [DataWidth-1:0] core_rdata_b_o,
    output logic                 core_rvalid_o,
    input  logic                 core_wr_i,
    input  logic [AddrWidth-1:0] core_waddr_i,
    input  logic [DataWidth-1:0] core_wdata_i,
    output logic                 core_stall_o,
    input  logic                 noc_valid_i,
    input  logic [AddrWidth-1:0] noc_addr_i,
    input  logic [DataWidth-1:0] noc_data_i,
    output logic                 noc_ready_o,
    input  logic                 desc_start_i,
    input  logic [AddrWidth-1:0] desc_base_i,
    input  logic [LenWidth-1:0]  desc_len_i,
    input  logic [DstWidth-1:0]  desc_dst_i,
    output logic                 desc_busy_o,
    output logic                 desc_done_o,
    output logic                 desc_valid_o,
    input  logic                 desc_ready_i,
    output logic [DataWidth-1:0] desc_data_o,
    output logic [DstWidth-1:0]  desc_dst_o,
    output logic                 ram_a_req_o,
    output logic                 ram_a_we_o,
    output logic [AddrWidth-1:0] ram_a_addr_o,
    output logic [DataWidth-1:0] ram_a_wdata_o,
    input  logic [DataWidth-1:0] ram_a_rdata_i,
    input  logic                 ram_a_rvalid_i,
    output logic                 ram_b_req_o,
    output logic                 ram_b_we_o,
    output logic [AddrWidth-1:0] ram_b_addr_o,
    output logic [DataWidth-1:0] ram_b_wdata_o,
    input  logic [DataWidth-1:0] ram_b_rdata_i,
    input  logic                 ram_b_rvalid_i
);

    typedef enum logic [1:0] {TagNone = 2'd0, TagCore = 2'd1, TagDesc = 2'd2} tag_e;
    typedef enum logic {SeqIdle = 1'b0, SeqRun = 1'b1} seq_e;

    tag_e                 tag_q, tag_d;
    seq_e                 seq_q, seq_d;

    logic                 hold_vld_q, hold_vld_d;
    logic [AddrWidth-1:0] hold_addr_q, hold_addr_d;
    logic [DataWidth-1:0] hold_data_q, hold_data_d;
    logic                 hold_retire, wr_direct, wr_capture;

    logic                 fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [DataWidth-1:0] fwd_data_q;

    logic [AddrWidth-1:0] seq_addr_q;
    logic [LenWidth-1:0]  seq_rem_q;
    logic [DstWidth-1:0]  seq_dst_q;
    logic [DataWidth-1:0] fifo_data_q [2];
    logic [DstWidth-1:0]  fifo_dst_q  [2];
    logic                 fifo_wptr_q, fifo_rptr_q;
    logic [1:0]           fifo_cnt_q;
    logic [2:0]           credits_used;
    logic                 start_ok, desc_issue, desc_push, desc_pop, last_accept;

    // A held write retires whenever the core is not reading; a new write may
    // refill the buffer in that same cycle, keeping writes in order.
    assign hold_retire  = hold_vld_q && !core_rd_i;
    assign wr_direct    = core_wr_i && !core_rd_i && !hold_vld_q;
    assign wr_capture   = core_wr_i && !wr_direct && (!hold_vld_q || hold_retire);
    assign core_stall_o = !rst_i && core_wr_i && hold_vld_q && core_rd_i;
    assign noc_ready_o  = !rst_i && !core_rd_i;

    assign credits_used = {1'b0, fifo_cnt_q} + {2'b00, tag_q == TagDesc};
    assign desc_issue   = (seq_q == SeqRun) && (seq_rem_q != '0) && (credits_used < 3'd2) &&
                          !core_rd_i && !hold_vld_q && !core_wr_i;
    assign start_ok     = (seq_q == SeqIdle) && desc_start_i && (desc_len_i != '0);
    assign desc_push    = (tag_q == TagDesc) && ram_a_rvalid_i;
    assign desc_valid_o = fifo_cnt_q != 2'd0;
    assign desc_pop     = desc_valid_o && desc_ready_i;
    assign last_accept  = (seq_q == SeqRun) && desc_pop && (fifo_cnt_q == 2'd1) &&
                          (seq_rem_q == '0) && (tag_q != TagDesc);

    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        if (hold_retire) hold_vld_d = 1'b0;
        if (wr_capture) begin
            hold_vld_d  = 1'b1;
            hold_addr_d = core_waddr_i;
            hold_data_d = core_wdata_i;
        end
    end

    // Forward from the post-update buffer so a same-cycle write is seen too.
    assign fwd_a_d = core_rd_i && hold_vld_d && (hold_addr_d == core_raddr_a_i);
    assign fwd_b_d = core_rd_i && hold_vld_d && (hold_addr_d == core_raddr_b_i);

    always_comb begin
        ram_a_req_o   = 1'b0;
        ram_a_we_o    = 1'b0;
        ram_a_addr_o  = '0;
        ram_a_wdata_o = '0;
        tag_d         = TagNone;
        if (!rst_i) begin
            if (core_rd_i) begin
                ram_a_req_o  = 1'b1;
                ram_a_addr_o = core_raddr_a_i;
                tag_d        = TagCore;
            end else if (hold_vld_q) begin
                ram_a_req_o   = 1'b1;
                ram_a_we_o    = 1'b1;
                ram_a_addr_o  = hold_addr_q;
                ram_a_wdata_o = hold_data_q;
            end else if (core_wr_i) begin
                ram_a_req_o   = 1'b1;
                ram_a_we_o    = 1'b1;
                ram_a_addr_o  = core_waddr_i;
                ram_a_wdata_o = core_wdata_i;
            end else if (desc_issue) begin
                ram_a_req_o  = 1'b1;
                ram_a_addr_o = seq_addr_q;
                tag_d        = TagDesc;
            end
        end
    end

    always_comb begin
        ram_b_req_o   = 1'b0;
        ram_b_we_o    = 1'b0;
        ram_b_addr_o  = '0;
        ram_b_wdata_o = '0;
        if (!rst_i) begin
            if (core_rd_i) begin
                ram_b_req_o  = 1'b1;
                ram_b_addr_o = core_raddr_b_i;
            end else if (noc_valid_i) begin
                ram_b_req_o   = 1'b1;
                ram_b_we_o    = 1'b1;
                ram_b_addr_o  = noc_addr_i;
                ram_b_wdata_o = noc_data_i;
            end
        end
    end

    assign core_rvalid_o  = (tag_q == TagCore) && ram_a_rvalid_i && ram_b_rvalid_i;
    assign core_rdata_a_o = !core_rvalid_o ? '0 : (fwd_a_q ? fwd_data_q : ram_a_rdata_i);
    assign core_rdata_b_o = !core_rvalid_o ? '0 : (fwd_b_q ? fwd_data_q : ram_b_rdata_i);
    assign desc_data_o    = desc_valid_o ? fifo_data_q[fifo_rptr_q] : '0;
    assign desc_dst_o     = desc_valid_o ? fifo_dst_q[fifo_rptr_q] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq_q <= SeqIdle;
        end else begin
            seq_q <= seq_d;
        end
    end

    always_comb begin
        seq_d = seq_q;
        case (seq_q)
            SeqIdle: if (start_ok) seq_d = SeqRun;
            SeqRun:  if (last_accept) seq_d = SeqIdle;
            default: seq_d = SeqIdle;
        endcase
    end

    always_comb begin
        desc_busy_o = (seq_q == SeqRun);
        desc_done_o = last_accept;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_vld_q  <= 1'b0;
            tag_q       <= TagNone;
            fwd_a_q     <= 1'b0;
            fwd_b_q     <= 1'b0;
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            seq_rem_q   <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            tag_q      <= tag_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            if (desc_push) fifo_wptr_q <= ~fifo_wptr_q;
            if (desc_pop) fifo_rptr_q <= ~fifo_rptr_q;
            fifo_cnt_q <= fifo_cnt_q + 2'(desc_push) - 2'(desc_pop);
            if (start_ok) seq_rem_q <= desc_len_i;
            else if (desc_issue) seq_rem_q <= seq_rem_q - LenWidth'(1);
        end
    end

    // Data-only registers; their validity is carried by the reset flags above.
    always_ff @(posedge clk_i) begin
        hold_addr_q <= hold_addr_d;
        hold_data_q <= hold_data_d;
        fwd_data_q  <= hold_data_d;
        if (start_ok) begin
            seq_addr_q <= desc_base_i;
            seq_dst_q  <= desc_dst_i;
        end else begin
            if (desc_issue) seq_addr_q <= seq_addr_q + AddrWidth'(1);
            if (desc_push) seq_dst_q <= seq_dst_q + DstWidth'(1);
        end
        if (desc_push) begin
            fifo_data_q[fifo_wptr_q] <= ram_a_rdata_i;
            fifo_dst_q[fifo_wptr_q]  <= seq_dst_q;
        end
    end

endmodule

// File: tb/tb_ibex_mprf_port_arbiter.sv
// Scoreboard bench for ibex_mprf_port_arbiter with a behavioural RAM and an
// architectural memory model of the MPRF.
module tb_ibex_mprf_port_arbiter;
    localparam int AW = 5, DW = 32, LW = 5, NW = 10;

    logic clk = 1'b0, rst = 1'b1, ram_load = 1'b1;
    always #5 clk = ~clk;

    logic          core_rd = 0, core_wr = 0, noc_valid = 0, desc_start = 0, desc_ready = 0;
    logic [AW-1:0] raddr_a = 0, raddr_b = 0, core_waddr = 0, noc_addr = 0, desc_base = 0;
    logic [DW-1:0] core_wdata = 0, noc_data = 0;
    logic [LW-1:0] desc_len = 0;
    logic [NW-1:0] desc_dst = 0;

    logic [DW-1:0] core_rdata_a_o, core_rdata_b_o, desc_data_o;
    logic          core_rvalid_o, core_stall_o, noc_ready_o, desc_busy_o, desc_done_o, desc_valid_o;
    logic [NW-1:0] desc_dst_o;
    logic          ram_a_req_o, ram_a_we_o, ram_b_req_o, ram_b_we_o;
    logic [AW-1:0] ram_a_addr_o, ram_b_addr_o;
    logic [DW-1:0] ram_a_wdata_o, ram_b_wdata_o, ram_a_rdata, ram_b_rdata;
    logic          ram_a_rvalid, ram_b_rvalid;

    ibex_mprf_port_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .core_rd_i(core_rd), .core_raddr_a_i(raddr_a), .core_raddr_b_i(raddr_b),
        .core_rdata_a_o(core_rdata_a_o), .core_rdata_b_o(core_rdata_b_o), .core_rvalid_o(core_rvalid_o),
        .core_wr_i(core_wr), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata), .core_stall_o(core_stall_o),
        .noc_valid_i(noc_valid), .noc_addr_i(noc_addr), .noc_data_i(noc_data), .noc_ready_o(noc_ready_o),
        .desc_start_i(desc_start), .desc_base_i(desc_base), .desc_len_i(desc_len), .desc_dst_i(desc_dst),
        .desc_busy_o(desc_busy_o), .desc_done_o(desc_done_o), .desc_valid_o(desc_valid_o),
        .desc_ready_i(desc_ready), .desc_data_o(desc_data_o), .desc_dst_o(desc_dst_o),
        .ram_a_req_o(ram_a_req_o), .ram_a_we_o(ram_a_we_o), .ram_a_addr_o(ram_a_addr_o),
        .ram_a_wdata_o(ram_a_wdata_o), .ram_a_rdata_i(ram_a_rdata), .ram_a_rvalid_i(ram_a_rvalid),
        .ram_b_req_o(ram_b_req_o), .ram_b_we_o(ram_b_we_o), .ram_b_addr_o(ram_b_addr_o),
        .ram_b_wdata_o(ram_b_wdata_o), .ram_b_rdata_i(ram_b_rdata), .ram_b_rvalid_i(ram_b_rvalid)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Dual-port RAM with one-cycle read latency.
    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        ram_a_rvalid <= 1'b0;
        ram_b_rvalid <= 1'b0;
        if (ram_load) for (int i = 0; i < 32; i++) ram[i] <= init_word(i);
        if (ram_a_req_o) begin
            if (ram_a_we_o) ram[ram_a_addr_o] <= ram_a_wdata_o;
            else begin ram_a_rdata <= ram[ram_a_addr_o]; ram_a_rvalid <= 1'b1; end
        end
        if (ram_b_req_o) begin
            if (ram_b_we_o) ram[ram_b_addr_o] <= ram_b_wdata_o;
            else begin ram_b_rdata <= ram[ram_b_addr_o]; ram_b_rvalid <= 1'b1; end
        end
    end

    logic any_out;
    assign any_out = |{core_rdata_a_o, core_rdata_b_o, core_rvalid_o, core_stall_o, noc_ready_o,
                       desc_busy_o, desc_done_o, desc_valid_o, desc_data_o, desc_dst_o,
                       ram_a_req_o, ram_a_we_o, ram_a_addr_o, ram_a_wdata_o,
                       ram_b_req_o, ram_b_we_o, ram_b_addr_o, ram_b_wdata_o};

    int total = 0, bad = 0;
    logic [DW-1:0] mem_m [32];
    logic [63:0] core_q [$];
    logic [63:0] wq [$];
    logic [42:0] desc_q [$];
    logic mbusy = 1'b0, wr_acc = 1'b0, noc_acc = 1'b0;
    int issued = 0, accepted = 0, done_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already applied; account for them, then advance.
    task automatic tick();
        logic [63:0] wexp;
        #1;
        if (!rst) begin
            check("core_stall", core_stall_o, core_wr && core_rd && wq.size() != 0);
            wr_acc = core_wr && !core_stall_o;
            if (wr_acc) begin
                mem_m[core_waddr] = core_wdata;
                wq.push_back({27'd0, core_waddr, core_wdata});
            end
            check("porta_write", ram_a_req_o && ram_a_we_o, !core_rd && wq.size() != 0);
            if (ram_a_req_o && ram_a_we_o && wq.size() != 0) begin
                wexp = wq.pop_front();
                check("porta_wr_data", {27'd0, ram_a_addr_o, ram_a_wdata_o}, wexp);
            end
            if (core_rd) core_q.push_back({mem_m[raddr_a], mem_m[raddr_b]});
            check("noc_ready", noc_ready_o, !core_rd);
            noc_acc = noc_valid && noc_ready_o;
            if (noc_acc) begin
                mem_m[noc_addr] = noc_data;
                check("portb_write", {ram_b_req_o, ram_b_we_o, ram_b_addr_o, ram_b_wdata_o},
                      {2'b11, noc_addr, noc_data});
            end
            if (desc_start && !mbusy && desc_len != 0) begin
                for (int i = 0; i < int'(desc_len); i++)
                    desc_q.push_back({i == int'(desc_len) - 1, NW'(int'(desc_dst) + i),
                                      mem_m[AW'(int'(desc_base) + i)]});
                mbusy = 1'b1; issued = 0; accepted = 0;
            end
            if (ram_a_req_o && !ram_a_we_o && !core_rd) issued++;
            if (mbusy) check("desc_credit", 64'((issued - accepted) <= 2), 64'd1);
        end
        @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT presents data.
    logic [63:0] mon_ce;
    logic [42:0] mon_de;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (core_rvalid_o) begin
                    if (core_q.size() == 0) check("core_rvalid_extra", core_rvalid_o, 0);
                    else begin
                        mon_ce = core_q.pop_front();
                        check("core_rdata", {core_rdata_a_o, core_rdata_b_o}, mon_ce);
                    end
                end
                if (desc_valid_o && desc_ready) begin
                    if (desc_q.size() == 0) check("desc_extra", desc_valid_o, 0);
                    else begin
                        mon_de = desc_q.pop_front();
                        check("desc_word", {desc_dst_o, desc_data_o}, {22'd0, mon_de[41:0]});
                        check("desc_done", desc_done_o, mon_de[42]);
                        accepted++;
                        if (mon_de[42]) begin mbusy = 1'b0; done_cnt++; end
                    end
                end else if (desc_done_o) check("desc_done_spurious", desc_done_o, 0);
            end
        end
    end

    task automatic wait_desc(input int limit);
        int n = 0;
        while (mbusy && n < limit) begin tick(); n++; end
        check("desc_finish", mbusy, 0);
    endtask

    int n, d0;
    initial begin
        for (int i = 0; i < 32; i++) mem_m[i] = init_word(i);
        @(negedge clk);
        ram_load = 1'b0;
        #1 check("reset_outputs", any_out, 0);
        @(negedge clk);
        rst = 1'b0;

        // Uncontended write then read-back.
        core_wr = 1; core_waddr = 3; core_wdata = 32'hDEAD; tick();
        core_wr = 0; core_rd = 1; raddr_a = 3; raddr_b = 4; tick();
        core_rd = 0; tick(); tick();

        // Read and write to the same address together: held and forwarded.
        core_rd = 1; raddr_a = 3; raddr_b = 4; core_wr = 1; core_waddr = 3; core_wdata = 32'h1234; tick();
        core_rd = 0; core_wr = 0; tick(); tick();

        // NoC write blocked by a three-cycle core read.
        core_rd = 1; raddr_a = 1; raddr_b = 2; noc_valid = 1; noc_addr = 7; noc_data = 32'hAA;
        repeat (3) tick();
        core_rd = 0; tick();
        noc_valid = 0; tick();

        // Descriptor wrapping both address and destination.
        d0 = done_cnt;
        desc_ready = 1; desc_start = 1; desc_base = 30; desc_len = 4; desc_dst = 10'h3FE; tick();
        desc_start = 0; wait_desc(100);
        check("wrap_done_count", 64'(done_cnt - d0), 64'd1);

        // Back-pressured descriptor.
        desc_ready = 0; desc_start = 1; desc_base = 10; desc_len = 3; desc_dst = 10'h005; tick();
        desc_start = 0; repeat (5) tick();
        desc_ready = 1; wait_desc(100);

        // Reset while a descriptor read is in flight.
        desc_ready = 0; desc_start = 1; desc_base = 20; desc_len = 8; desc_dst = 10'h100; tick();
        desc_start = 0; n = 0;
        while (issued == 0 && n < 20) begin tick(); n++; end
        check("midrst_read_issued", 64'(issued != 0), 64'd1);
        rst = 1'b1; desc_q.delete(); mbusy = 1'b0; issued = 0; accepted = 0;
        #1 check("midrst_outputs", any_out, 0);
        @(negedge clk);
        #1 check("midrst_outputs_hold", any_out, 0);
        @(negedge clk);
        rst = 1'b0; desc_ready = 1;
        repeat (4) begin tick(); check("midrst_quiet", desc_valid_o | desc_busy_o, 0); end

        // Random core/NoC traffic with disjoint write ranges.
        desc_ready = 0;
        for (int c = 0; c < 1500; c++) begin
            core_rd = $urandom_range(0, 9) < 4;
            raddr_a = AW'($urandom_range(0, 23)); raddr_b = AW'($urandom_range(0, 23));
            if (!core_wr || wr_acc) begin
                core_wr = $urandom_range(0, 9) < 4;
                core_waddr = AW'($urandom_range(0, 15)); core_wdata = $urandom;
            end
            if (!noc_valid || noc_acc) begin
                noc_valid = $urandom_range(0, 9) < 3;
                noc_addr = AW'($urandom_range(16, 23)); noc_data = $urandom;
            end
            tick();
        end
        while ((core_wr && !wr_acc) || (noc_valid && !noc_acc)) begin
            core_rd = 0; tick();
            if (wr_acc) core_wr = 0;
            if (noc_acc) noc_valid = 0;
        end
        core_rd = 0; core_wr = 0; noc_valid = 0; tick(); tick();

        // Random descriptors against random core reads and back-pressure.
        for (int k = 0; k < 12; k++) begin
            desc_base = AW'($urandom_range(0, 31)); desc_len = LW'($urandom_range(0, 6));
            desc_dst = NW'($urandom_range(0, 1023)); desc_start = 1;
            tick();
            desc_start = 0;
            if (desc_len == 0) check("len0_idle", desc_busy_o, 0);
            n = 0;
            while (mbusy && n < 400) begin
                core_rd = $urandom_range(0, 9) < 3;
                raddr_a = AW'($urandom_range(0, 31)); raddr_b = AW'($urandom_range(0, 31));
                desc_ready = $urandom_range(0, 9) < 6;
                desc_start = $urandom_range(0, 9) == 0;
                desc_base = AW'($urandom_range(0, 31)); desc_len = LW'($urandom_range(1, 6));
                tick(); n++;
            end
            desc_start = 0; core_rd = 0;
            check("rand_desc_finish", mbusy, 0);
        end

        desc_ready = 0;
        repeat (3) tick();
        check("core_q_empty", 64'(core_q.size()), 0);
        check("desc_q_empty", 64'(desc_q.size()), 0);
        check("wq_empty", 64'(wq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
